// File: rtl/bitrev_pingpong_sort.sv
// Bit-reversal reorder buffer with ping-pong banks: one frame is written while the other is read out.
// Optional macro BITREV_FRAME_CNT_EN adds a 16-bit count of fully emitted frames.
module bitrev_pingpong_sort #(
    parameter int WIDTH = 24,
    parameter int LOG2N = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_r,
    input  logic [WIDTH-1:0]   in_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_r,
    output logic [WIDTH-1:0]   out_i,
    output logic [LOG2N-1:0]   out_idx,
    output logic               out_last
`ifdef BITREV_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int N = 2 ** LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

    // Both banks live in one array; the bank select is the address MSB.
    logic [2*WIDTH-1:0] mem [0:2*N-1];

    logic [LOG2N-1:0] wcnt_reg;
    logic [LOG2N-1:0] rcnt_reg;
    logic             wbank_reg;
    logic             rbank_reg;
    logic [1:0]       full_reg;
    logic [1:0]       bmode_reg;

    logic [LOG2N-1:0] wcnt_rev;
    logic [LOG2N-1:0] waddr;
    logic             frame_mode;
    logic             accept;
    logic             xfer;
    logic [2*WIDTH-1:0] rdata;

    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_rev
            assign wcnt_rev[gi] = wcnt_reg[LOG2N-1-gi];
        end
    endgenerate

    // The first sample of a frame uses the live mode input, later samples the latched one.
    assign frame_mode = (wcnt_reg == '0) ? mode : bmode_reg[wbank_reg];
    assign waddr      = frame_mode ? wcnt_rev : wcnt_reg;

    assign in_ready  = !full_reg[wbank_reg] && !rst && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = full_reg[rbank_reg];
    assign xfer      = out_valid && out_ready;

    assign rdata    = mem[{rbank_reg, rcnt_reg}];
    assign out_r    = out_valid ? rdata[2*WIDTH-1:WIDTH] : '0;
    assign out_i    = out_valid ? rdata[WIDTH-1:0] : '0;
    assign out_idx  = rcnt_reg;
    assign out_last = out_valid && (rcnt_reg == LAST_IDX);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{wbank_reg, waddr}] <= {in_r, in_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wcnt_reg  <= '0;
            rcnt_reg  <= '0;
            wbank_reg <= 1'b0;
            rbank_reg <= 1'b0;
            full_reg  <= 2'b00;
            bmode_reg <= 2'b00;
        end else begin
            if (accept) begin
                if (wcnt_reg == '0) begin
                    bmode_reg[wbank_reg] <= mode;
                end
                wcnt_reg <= wcnt_reg + LOG2N'(1);
                if (wcnt_reg == LAST_IDX) begin
                    full_reg[wbank_reg] <= 1'b1;
                    wbank_reg           <= ~wbank_reg;
                end
            end
            // A read transfer only happens from a full bank, so it never clashes with the write bank.
            if (xfer) begin
                rcnt_reg <= rcnt_reg + LOG2N'(1);
                if (rcnt_reg == LAST_IDX) begin
                    full_reg[rbank_reg] <= 1'b0;
                    rbank_reg           <= ~rbank_reg;
                end
            end
        end
    end

`ifdef BITREV_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (xfer && out_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bitrev_pingpong_sort.sv
// Directed bench for bitrev_pingpong_sort (WIDTH=24, LOG2N=4) with hand-computed expectations.
module tb_bitrev_pingpong_sort;

    localparam int WIDTH = 24;
    localparam int LOG2N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             mode = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_r = '0;
    logic [WIDTH-1:0] in_i = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_i;
    logic [LOG2N-1:0] out_idx;
    logic             out_last;
`ifdef BITREV_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int rev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    bitrev_pingpong_sort #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst), .flush(flush), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
        .out_idx(out_idx), .out_last(out_last)
`ifdef BITREV_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // Feed 16 samples base+k / 100+base+k; mode inverts from sample index flip onward.
    task automatic feed(input int base, input logic m, input int flip);
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_r = WIDTH'(base + k);
            in_i = WIDTH'(100 + base + k);
            mode = (k >= flip) ? ~m : m;
            #1;
            for (int t = 0; t < 200 && !in_ready; t++) begin
                tick();
            end
            if (!in_ready) check("feed_timeout", 0, 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
    endtask

    // Read one frame with out_ready=1, checking data, index and last flag per sample.
    task automatic drain(input string tag, input int base, input logic bitrev);
        int e;
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            #1;
            for (int t = 0; t < 200 && !out_valid; t++) begin
                tick();
            end
            e = base + (bitrev ? rev_tab[j] : j);
            check($sformatf("%s_r[%0d]", tag, j), out_r, e);
            check($sformatf("%s_i[%0d]", tag, j), out_i, 100 + e);
            check($sformatf("%s_idx[%0d]", tag, j), out_idx, j);
            check($sformatf("%s_last[%0d]", tag, j), out_last, (j == 15) ? 1 : 0);
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int acc;
        int outs;
        int started;
        int gaps;
        int xf;

        // Reset state
        tick(); #1;
        check("rst_in_ready_held", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_r", out_r, 0);
        rst = 1'b0;
        tick();
        check("rst_in_ready_release", in_ready, 1);

        // Bit-reverse frame
        feed(0, 1'b1, 16);
        check("br_first_valid", out_valid, 1);
        drain("br", 0, 1'b1);

        // Natural frame; mode flip at k=5 must not matter
        feed(0, 1'b0, 5);
        drain("nat", 0, 1'b0);

        // Streaming: 4 frames, continuous in and out
        do_reset();
        mode = 1'b1;
        out_ready = 1'b1;
        acc = 0; outs = 0; started = 0; gaps = 0;
        for (int c = 0; c < 120 && outs < 64; c++) begin
            in_valid = (acc < 64);
            in_r = WIDTH'(acc);
            in_i = WIDTH'(100 + acc);
            #1;
            if (acc < 64 && !in_ready) gaps++;
            if (out_valid) begin
                started = 1;
                if (out_r !== WIDTH'((outs / 16) * 16 + rev_tab[outs % 16])) gaps++;
                outs++;
            end else if (started) begin
                gaps++;
            end
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("stream_outputs", outs, 64);
        check("stream_gaps_or_errors", gaps, 0);
`ifdef BITREV_FRAME_CNT_EN
        check("stream_frame_cnt", frame_cnt, 4);
`endif

        // Backpressure
        do_reset();
        mode = 1'b1;
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1;
            in_r = WIDTH'(acc);
            in_i = WIDTH'(100 + acc);
            #1;
            if (!in_ready) break;
            acc++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepts", acc, 32);
        check("bp_out_valid", out_valid, 1);
        check("bp_out_r", out_r, 0);
        tick(); tick();
        check("bp_out_valid_held", out_valid, 1);
        check("bp_out_idx_held", out_idx, 0);
        out_ready = 1'b1;
        xf = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (in_ready) break;
            if (out_valid) xf++;
            tick();
        end
        check("bp_transfers_to_ready", xf, 16);
        for (int c = 0; c < 20; c++) tick();
        check("bp_drained", out_valid, 0);

        // Flush after 7 accepts
        do_reset();
        mode = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; in_r = WIDTH'(500 + k); in_i = WIDTH'(600 + k);
            tick();
        end
        flush = 1'b1;
        #1;
        check("flush_in_ready_during", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready_after", in_ready, 1);
        feed(200, 1'b1, 16);
        drain("flush_frame", 200, 1'b1);

        // Reset in the middle of readout
        feed(40, 1'b1, 16);
        out_ready = 1'b1;
        for (int c = 0; c < 50 && out_idx != 5; c++) tick();
        check("mid_idx_reached", out_idx, 5);
        rst = 1'b1;
        #1;
        check("mid_in_ready_rst", in_ready, 0);
        tick();
        check("mid_out_valid", out_valid, 0);
        check("mid_out_r", out_r, 0);
        check("mid_in_ready_held", in_ready, 0);
        rst = 1'b0;
        tick();
        check("mid_in_ready_release", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
